frame_blitter: RTL and testbench

Parametrised full-frame image blitter for the VGA adapter path. On a `start` pulse it walks every pixel of an `H_RES`×`V_RES` frame in raster order. For each pixel it issues a read address to a bank of `NUM_IMG` image ROMs and emits registered (x, y, colour, plot) writes aligned to the ROM read latency. It generalises the single-image splash/victory/death drawers with runtime image select, configurable ROM latency, a transparent colour key, and a start/busy/done handshake. It sits between the game-control FSM and the VGA adapter write port.

---
 rtl/frame_blitter_pkg.sv | 16 +
 rtl/frame_blitter_if.sv | 38 +++
 rtl/frame_blitter_raster_counter.sv | 62 ++++++
 rtl/frame_blitter.sv | 173 +++++++++++++++++
 tb/tb_frame_blitter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_blitter_pkg.sv
// Shared definitions for the frame blitter slice.
// Holds the blitter state encoding and the default VGA frame geometry.
// No ports: imported by frame_blitter and raster_counter.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } blit_state_t;

    localparam int H_RES_DEF  = 32'd160;
    localparam int V_RES_DEF  = 32'd120;
    localparam int PIXELS_DEF = H_RES_DEF * V_RES_DEF;

endpackage

// File: rtl/frame_blitter_if.sv
// Bus bundle between the blitter, its control FSM, the image ROM bank and
// the VGA adapter write port.
//   start/img_sel/key_en/key_col : blit request from the game controller
//   busy/done                    : blit status back to the controller
//   rom_addr/rom_data            : shared ROM read address, concatenated data
//   out_x/out_y/out_col/plot     : pixel write towards the adapter
// master = the blitter side, slave = everything around it.
interface frame_blitter_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int NUM_IMG = 3,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 15
) ();
    logic                     start;
    logic [SEL_W-1:0]         img_sel;
    logic                     key_en;
    logic [COL_W-1:0]         key_col;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        rom_addr;
    logic [NUM_IMG*COL_W-1:0] rom_data;
    logic [X_W-1:0]           out_x;
    logic [Y_W-1:0]           out_y;
    logic [COL_W-1:0]         out_col;
    logic                     plot;

    modport master (
        input  start, img_sel, key_en, key_col, rom_data,
        output busy, done, rom_addr, out_x, out_y, out_col, plot
    );

    modport slave (
        output start, img_sel, key_en, key_col, rom_data,
        input  busy, done, rom_addr, out_x, out_y, out_col, plot
    );
endinterface

// File: rtl/frame_blitter_raster_counter.sv
// Raster-order x/y/address counter for the frame blitter.
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : force x, y and addr back to 0 (takes priority over en)
//   en             : advance one pixel
//   x, y, addr     : registered current pixel position and linear address
//   last           : current position is the bottom-right pixel
// The counter saturates on the last pixel so addr never passes H_RES*V_RES-1.
module raster_counter
    import blit_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              en,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic [ADDR_W-1:0] addr_r;
    logic              row_end_s;
    logic              last_s;

    assign row_end_s = (x_r == X_W'(H_RES - 1));
    assign last_s    = row_end_s && (y_r == Y_W'(V_RES - 1));

    // Position/address register: clear, advance in raster order, or hold.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            x_r    <= {X_W{1'b0}};
            y_r    <= {Y_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (en && !last_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (row_end_s) begin
                x_r <= {X_W{1'b0}};
                y_r <= y_r + Y_W'(1);
            end else begin
                x_r <= x_r + X_W'(1);
            end
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            addr_r <= addr_r;
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign addr = addr_r;
    assign last = last_s;

endmodule

// File: rtl/frame_blitter.sv
// Full-frame image blitter: on start, walks an H_RES x V_RES frame in raster
// order, reads the selected image ROM and emits registered pixel writes
// aligned to the ROM read latency, with an optional transparent colour key.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (master)   : start/img_sel/key_en/key_col in, busy/done out,
//                    rom_addr out / rom_data in, out_x/out_y/out_col/plot out
module frame_blitter
    import blit_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int NUM_IMG = 3,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 15,
    parameter int ROM_LAT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    frame_blitter_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]       state_r;
    logic             busy_r;
    logic             done_r;
    logic [SEL_W-1:0] img_sel_r;
    logic             key_en_r;
    logic [COL_W-1:0] key_col_r;
    logic [2:0]       drain_cnt_r;

    logic             accept_s;
    logic             scan_s;
    logic [X_W-1:0]   scan_x_s;
    logic [Y_W-1:0]   scan_y_s;
    logic             scan_last_s;

    // Delay line tracking each pixel through the ROM read latency.
    logic             dl_v_r [ROM_LAT];
    logic [X_W-1:0]   dl_x_r [ROM_LAT];
    logic [Y_W-1:0]   dl_y_r [ROM_LAT];

    logic [COL_W-1:0] pix_col_s;
    logic [X_W-1:0]   out_x_r;
    logic [Y_W-1:0]   out_y_r;
    logic [COL_W-1:0] out_col_r;
    logic             plot_r;

    assign accept_s = (state_r == ST_IDLE) && bus.start;
    assign scan_s   = (state_r == ST_SCAN);

    raster_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept_s),
        .en      (scan_s),
        .x       (scan_x_s),
        .y       (scan_y_s),
        .addr    (bus.rom_addr),
        .last    (scan_last_s)
    );

    // Control FSM: accept a request, scan the frame, then flush the pipeline.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            img_sel_r   <= {SEL_W{1'b0}};
            key_en_r    <= 1'b0;
            key_col_r   <= {COL_W{1'b0}};
            drain_cnt_r <= 3'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r   <= ST_SCAN;
                        busy_r    <= 1'b1;
                        img_sel_r <= bus.img_sel;
                        key_en_r  <= bus.key_en;
                        key_col_r <= bus.key_col;
                    end
                end
                ST_SCAN: begin
                    if (scan_last_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= 3'd0;
                    end
                end
                ST_DRAIN: begin
                    // ROM_LAT+1 drain cycles so done follows the last pixel write.
                    if (drain_cnt_r == 3'(ROM_LAT)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Delay line: stage 0 captures the pixel whose address is on the ROM bus.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_v_r[i] <= 1'b0;
                dl_x_r[i] <= {X_W{1'b0}};
                dl_y_r[i] <= {Y_W{1'b0}};
            end
        end else begin
            dl_v_r[0] <= scan_s;
            dl_x_r[0] <= scan_x_s;
            dl_y_r[0] <= scan_y_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_v_r[i] <= dl_v_r[i-1];
                dl_x_r[i] <= dl_x_r[i-1];
                dl_y_r[i] <= dl_y_r[i-1];
            end
        end
    end

    // Image select mux; an out-of-range select yields colour 0.
    always_comb begin
        pix_col_s = {COL_W{1'b0}};
        for (int i = 0; i < NUM_IMG; i++) begin
            pix_col_s = (img_sel_r == SEL_W'(i)) ? bus.rom_data[i*COL_W +: COL_W]
                                                 : pix_col_s;
        end
    end

    // Output stage: position/colour follow every valid pixel, plot is keyed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_x_r   <= {X_W{1'b0}};
            out_y_r   <= {Y_W{1'b0}};
            out_col_r <= {COL_W{1'b0}};
            plot_r    <= 1'b0;
        end else if (dl_v_r[ROM_LAT-1]) begin
            out_x_r   <= dl_x_r[ROM_LAT-1];
            out_y_r   <= dl_y_r[ROM_LAT-1];
            out_col_r <= pix_col_s;
            plot_r    <= !(key_en_r && (pix_col_s == key_col_r));
        end else begin
            plot_r    <= 1'b0;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.out_x   = out_x_r;
    assign bus.out_y   = out_y_r;
    assign bus.out_col = out_col_r;
    assign bus.plot    = plot_r;

endmodule

// File: tb/tb_frame_blitter.sv
// Bench for frame_blitter: a 160x120/latency-1 instance and a 4x2/latency-3
// instance, each fed by a latency-matched ROM bank. A frame-level model
// predicts every output per cycle from the start edge; literal counts pin it.
module tb_frame_blitter;
    import blit_pkg::*;

    localparam int NA = H_RES_DEF * V_RES_DEF;
    localparam int HA = H_RES_DEF;
    localparam int LA = 1;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int NB = HB * VB;
    localparam int LB = 3;

    typedef struct {
        bit active;
        bit done_now;
        bit rst_now;
        int c;
        int sel;
        bit ken;
        int kcol;
    } mstate_t;

    logic clock = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    mstate_t ms [2];
    int plots [2];
    int dones [2];
    int col0 [2];
    int pix52 [2];
    int first_plot [2];
    int done_edge [2];
    int e0_edge [2];

    always #5 clock = ~clock;

    frame_blitter_if bus_a ();
    frame_blitter_if bus_b ();

    frame_blitter dut_a (
        .clock   (clock),
        .reset_n (reset_a),
        .bus     (bus_a)
    );

    frame_blitter #(.H_RES(HB), .V_RES(VB), .ROM_LAT(LB)) dut_b (
        .clock   (clock),
        .reset_n (reset_b),
        .bus     (bus_b)
    );

    // Image contents: three different functions of the address.
    function automatic int rom_col(input int img, input int a);
        case (img)
            0:       return (a * 5 + 3) % 8;
            1:       return a % 8;
            2:       return (a / 8) % 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [8:0] rom_word(input int a);
        return {3'(rom_col(2, a)), 3'(rom_col(1, a)), 3'(rom_col(0, a))};
    endfunction

    logic [8:0] rda;
    logic [8:0] rdb [3];
    always @(posedge clock) begin
        rda    <= rom_word(int'(bus_a.rom_addr));
        rdb[0] <= rom_word(int'(bus_b.rom_addr));
        rdb[1] <= rdb[0];
        rdb[2] <= rdb[1];
    end
    assign bus_a.rom_data = rda;
    assign bus_b.rom_data = rdb[2];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", nm, id, edge_cnt, act, exp);
        end
    endtask

    task automatic clear_stats(input int id);
        plots[id] = 0; dones[id] = 0; col0[id] = 0; pix52[id] = -1;
        first_plot[id] = -1; done_edge[id] = -1;
    endtask

    // Frame model: cycle index c counts edges since the accepting edge.
    task automatic model_step(input int id, input int n, input int l, input bit rst,
                              input bit st, input int sel, input bit ken, input int kcol);
        ms[id].done_now = 1'b0;
        ms[id].rst_now  = 1'b0;
        if (rst) begin
            ms[id].active  = 1'b0;
            ms[id].rst_now = 1'b1;
        end else if (ms[id].active) begin
            ms[id].c++;
            if (ms[id].c == n + l + 1) begin
                ms[id].active   = 1'b0;
                ms[id].done_now = 1'b1;
            end
        end else if (st) begin
            ms[id].active = 1'b1;
            ms[id].c      = 0;
            ms[id].sel    = sel;
            ms[id].ken    = ken;
            ms[id].kcol   = kcol;
            e0_edge[id]   = edge_cnt;
        end
    endtask

    task automatic check_dut(input int id, input int n, input int h, input int l,
                             input logic busy, input logic done, input logic [14:0] addr,
                             input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] col, input logic plot);
        bit inf, pv, eplot;
        int pn, ecol;
        inf   = ms[id].active || ms[id].done_now;
        pn    = ms[id].c - l - 1;
        pv    = inf && (pn >= 0) && (pn < n);
        ecol  = (pv && ms[id].sel < 3) ? rom_col(ms[id].sel, pn) : 0;
        eplot = pv && !(ms[id].ken && (ecol == ms[id].kcol));
        chk("busy", id, 32'(busy), 32'(ms[id].active));
        chk("done", id, 32'(done), 32'(ms[id].done_now));
        chk("plot", id, 32'(plot), 32'(eplot));
        if (ms[id].active)
            chk("rom_addr", id, 32'(addr), (ms[id].c < n) ? ms[id].c : n - 1);
        if (pv) begin
            chk("out_x", id, 32'(x), pn % h);
            chk("out_y", id, 32'(y), pn / h);
            chk("out_col", id, 32'(col), ecol);
        end
        if (ms[id].rst_now) begin
            chk("rst_addr", id, 32'(addr), 0);
            chk("rst_xycol", id, {x, y, col}, 0);
        end
        if (done === 1'b1) begin
            dones[id]++;
            if (done_edge[id] < 0) done_edge[id] = edge_cnt;
        end
        if (plot === 1'b1) begin
            plots[id]++;
            if (col == 3'd0) col0[id]++;
            if (first_plot[id] < 0) first_plot[id] = edge_cnt;
            if (x == 8'd5 && y == 7'd2) pix52[id] = int'(col);
        end
    endtask

    // Compare process: model advances on each rising edge, outputs checked on the falling edge.
    initial begin
        ms[0] = '{default: 0};
        ms[1] = '{default: 0};
        forever begin
            @(posedge clock);
            edge_cnt++;
            model_step(0, NA, LA, !reset_a, bus_a.start, int'(bus_a.img_sel), bus_a.key_en, int'(bus_a.key_col));
            model_step(1, NB, LB, !reset_b, bus_b.start, int'(bus_b.img_sel), bus_b.key_en, int'(bus_b.key_col));
            @(negedge clock);
            check_dut(0, NA, HA, LA, bus_a.busy, bus_a.done, bus_a.rom_addr, bus_a.out_x,
                      bus_a.out_y, bus_a.out_col, bus_a.plot);
            check_dut(1, NB, HB, LB, bus_b.busy, bus_b.done, bus_b.rom_addr, bus_b.out_x,
                      bus_b.out_y, bus_b.out_col, bus_b.plot);
        end
    end

    task automatic wait_done(input int id, input int budget, input string nm);
        int k = 0;
        while (dones[id] == 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        chk(nm, id, 32'(dones[id] > 0), 32'd1);
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_addr_a(input int a, input string nm);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (int'(bus_a.rom_addr) != a && k < 30000);
        chk(nm, 0, 32'(bus_a.rom_addr), a);
    endtask

    task automatic start_a(input int sel, input bit ken, input int kcol);
        @(negedge clock);
        clear_stats(0);
        bus_a.img_sel = 2'(sel); bus_a.key_en = ken; bus_a.key_col = 3'(kcol);
        bus_a.start = 1'b1;
        @(negedge clock);
        bus_a.start = 1'b0;
        bus_a.img_sel = 2'd0; bus_a.key_en = 1'b0; bus_a.key_col = 3'd0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.start = 1'b0; bus_a.img_sel = 2'd0; bus_a.key_en = 1'b0; bus_a.key_col = 3'd0;
        bus_b.start = 1'b0; bus_b.img_sel = 2'd0; bus_b.key_en = 1'b0; bus_b.key_col = 3'd0;
        clear_stats(0);
        clear_stats(1);
        repeat (3) @(negedge clock);
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(negedge clock);

        // Plain frame of image 1, with an ignored restart at address 500.
        start_a(1, 1'b0, 0);
        wait_addr_a(500, "a1_reach_500");
        bus_a.start = 1'b1; bus_a.img_sel = 2'd2;
        @(negedge clock);
        bus_a.start = 1'b0; bus_a.img_sel = 2'd0;
        wait_done(0, 20000, "a1_done_seen");
        chk("a1_plots", 0, plots[0], 32'd19200);
        chk("a1_dones", 0, dones[0], 32'd1);
        chk("a1_done_lat", 0, done_edge[0] - e0_edge[0], 32'd19202);
        chk("a1_pix52", 0, pix52[0], 32'd5);

        // Colour key 0 on image 1: one pixel in eight is transparent.
        start_a(1, 1'b1, 0);
        wait_done(0, 20000, "a2_done_seen");
        chk("a2_plots", 0, plots[0], 32'd16800);
        chk("a2_col0", 0, col0[0], 32'd0);

        // One-cycle reset at address 1000 aborts the frame.
        start_a(1, 1'b0, 0);
        wait_addr_a(1000, "a3_reach_1000");
        reset_a = 1'b0;
        @(negedge clock);
        reset_a = 1'b1;
        repeat (20) @(negedge clock);
        chk("a3_no_done", 0, dones[0], 32'd0);
        chk("a3_idle_busy", 0, 32'(bus_a.busy), 32'd0);

        // Out-of-range image select: full frame of colour 0.
        start_a(3, 1'b0, 0);
        wait_done(0, 20000, "a4_done_seen");
        chk("a4_plots", 0, plots[0], 32'd19200);
        chk("a4_col0", 0, col0[0], 32'd19200);
        chk("a4_dones", 0, dones[0], 32'd1);

        // Small frame, latency 3.
        @(negedge clock);
        clear_stats(1);
        bus_b.img_sel = 2'd1; bus_b.start = 1'b1;
        @(negedge clock);
        bus_b.start = 1'b0;
        wait_done(1, 100, "b1_done_seen");
        chk("b1_plots", 1, plots[1], 32'd8);
        chk("b1_first_plot", 1, first_plot[1] - e0_edge[1], 32'd4);
        chk("b1_done_lat", 1, done_edge[1] - e0_edge[1], 32'd12);

        // Start held high: back-to-back frames with a one-cycle gap.
        clear_stats(1);
        bus_b.img_sel = 2'd0; bus_b.start = 1'b1;
        repeat (40) @(negedge clock);
        bus_b.start = 1'b0;
        repeat (20) @(negedge clock);
        chk("b2_dones", 1, dones[1], 32'd4);
        chk("b2_plots", 1, plots[1], 32'd32);

        // Random requests, image selects, keys and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus_b.start   = ($urandom % 3 == 0);
            bus_b.img_sel = 2'($urandom % 4);
            bus_b.key_en  = 1'($urandom % 2);
            bus_b.key_col = 3'($urandom % 8);
            reset_b       = ($urandom % 40 != 0);
            @(negedge clock);
        end
        bus_b.start = 1'b0;
        reset_b = 1'b1;
        repeat (20) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
